// File: rtl/apb_master_ctrl_if.sv
// Signal bundle between apb_master_ctrl, the ICB register bank and FIFOs, and the APB slaves.
interface apb_master_ctrl_if #(
    parameter int NUM_SLV = 4
);
    logic               apb_en;
    logic               wfifo_empty;
    logic [63:0]        wfifo_rdata;
    logic               wfifo_ren;
    logic               rfifo_full;
    logic               rfifo_wen;
    logic [63:0]        rfifo_wdata;
    logic [1:0]         apb_state;
    logic [NUM_SLV-1:0] psel;
    logic               penable;
    logic               pwrite;
    logic [31:0]        paddr;
    logic [31:0]        pwdata;
    logic [31:0]        prdata;
    logic               pready;
    logic               pslverr;
    logic               timeout_err;

    modport master (
        input  apb_en, wfifo_empty, wfifo_rdata, rfifo_full, prdata, pready, pslverr,
        output wfifo_ren, rfifo_wen, rfifo_wdata, apb_state, psel, penable, pwrite,
               paddr, pwdata, timeout_err
    );

    modport slave (
        output apb_en, wfifo_empty, wfifo_rdata, rfifo_full, prdata, pready, pslverr,
        input  wfifo_ren, rfifo_wen, rfifo_wdata, apb_state, psel, penable, pwrite,
               paddr, pwdata, timeout_err
    );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB3 master: pops 64-bit command words from the write FIFO, runs one APB transfer
// per word and pushes read results (with error flag) into the read FIFO.
module apb_master_ctrl #(
    parameter int TIMEOUT_CYC = 256,
    parameter int NUM_SLV     = 4,
    parameter int SEL_LSB     = 12
) (
    input  logic              clk,
    input  logic              rst,
    apb_master_ctrl_if.master bus
);
    localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_RST    = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_POP    = 3'd3,
        S_FETCH  = 3'd4,
        S_HOLD   = 3'd5,
        S_SETUP  = 3'd6,
        S_ACCESS = 3'd7
    } state_e;

    state_e             state_q, state_d;
    state_e             fin_state_s;
    logic [1:0]         apb_state_q, apb_state_d;
    logic               wfifo_ren_q, wfifo_ren_d;
    logic               rfifo_wen_q, rfifo_wen_d;
    logic               rd_err_q, rd_err_d;
    logic [31:0]        rd_data_q, rd_data_d;
    logic [NUM_SLV-1:0] psel_q, psel_d;
    logic               penable_q, penable_d;
    logic               pwrite_q, pwrite_d;
    logic [31:0]        paddr_q, paddr_d;
    logic [31:0]        pwdata_q, pwdata_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [29:0]        cmd_addr_q;
    logic [31:0]        cmd_wdata_q;
    logic               cmd_write_q;
    logic [31:0]        src_addr_s;
    logic [31:0]        src_wdata_s;
    logic               src_write_s;
    logic               pop_ok_s;
    logic               rsvd_unused_s;

    // Indices at or above NUM_SLV never match, so an unmapped address yields an all-zero select.
    function automatic logic [NUM_SLV-1:0] sel_decode(input logic [31:0] addr);
        logic [NUM_SLV-1:0] sel;
        sel = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel[i] = (addr[SEL_LSB+2:SEL_LSB] == 3'(i));
        end
        return sel;
    endfunction

    assign rsvd_unused_s = bus.wfifo_rdata[1];
    assign pop_ok_s      = bus.apb_en && !bus.wfifo_empty;
    assign fin_state_s   = pop_ok_s ? S_POP : S_IDLE;

    // Command source: the FIFO word while it is being fetched, the latched command afterwards.
    always_comb begin
        src_addr_s  = (state_q == S_FETCH) ? {bus.wfifo_rdata[31:2], 2'b00} : {cmd_addr_q, 2'b00};
        src_wdata_s = (state_q == S_FETCH) ? bus.wfifo_rdata[63:32] : cmd_wdata_q;
        src_write_s = (state_q == S_FETCH) ? bus.wfifo_rdata[0] : cmd_write_q;
    end

    // Next-state and next-output logic; every output is a flop loaded from these values.
    always_comb begin
        state_d       = state_q;
        apb_state_d   = apb_state_q;
        wfifo_ren_d   = 1'b0;
        rfifo_wen_d   = 1'b0;
        rd_err_d      = rd_err_q;
        rd_data_d     = rd_data_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        timeout_err_d = timeout_err_q;
        cnt_d         = cnt_q;
        case (state_q)
            S_RST: begin
                state_d     = S_INIT;
                apb_state_d = 2'd0;
            end
            S_INIT: begin
                state_d     = S_IDLE;
                apb_state_d = 2'd1;
            end
            S_IDLE: begin
                state_d     = fin_state_s;
                wfifo_ren_d = pop_ok_s;
                apb_state_d = 2'd1;
            end
            S_POP: begin
                state_d = S_FETCH;
            end
            S_FETCH, S_HOLD: begin
                if (src_write_s || !bus.rfifo_full) begin
                    state_d     = S_SETUP;
                    apb_state_d = src_write_s ? 2'd3 : 2'd2;
                    psel_d      = sel_decode(src_addr_s);
                    penable_d   = 1'b0;
                    paddr_d     = src_addr_s;
                    pwrite_d    = src_write_s;
                    pwdata_d    = src_wdata_s;
                    cnt_d       = '0;
                end else begin
                    state_d     = S_HOLD;
                    apb_state_d = 2'd2;
                end
            end
            S_SETUP: begin
                if (psel_q == '0) begin
                    state_d     = fin_state_s;
                    wfifo_ren_d = pop_ok_s;
                    apb_state_d = 2'd1;
                    rfifo_wen_d = !pwrite_q;
                    if (!pwrite_q) begin
                        rd_err_d  = 1'b1;
                        rd_data_d = 32'h0000_0000;
                    end else begin
                        rd_err_d  = rd_err_q;
                        rd_data_d = rd_data_q;
                    end
                end else begin
                    state_d   = S_ACCESS;
                    penable_d = 1'b1;
                end
            end
            S_ACCESS: begin
                // Completion and timeout share the exit; only a timeout lacks pready.
                if (bus.pready || ((cnt_q + CNT_ONE) == CNT_LIM)) begin
                    state_d       = fin_state_s;
                    wfifo_ren_d   = pop_ok_s;
                    apb_state_d   = 2'd1;
                    psel_d        = '0;
                    penable_d     = 1'b0;
                    rfifo_wen_d   = !pwrite_q;
                    timeout_err_d = timeout_err_q | !bus.pready;
                    if (!pwrite_q) begin
                        rd_err_d  = bus.pready ? bus.pslverr : 1'b1;
                        rd_data_d = bus.pready ? bus.prdata : 32'h0000_0000;
                    end else begin
                        rd_err_d  = rd_err_q;
                        rd_data_d = rd_data_q;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d     = S_RST;
                apb_state_d = 2'd0;
                psel_d      = '0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // State, command and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_RST;
            apb_state_q   <= 2'd0;
            wfifo_ren_q   <= 1'b0;
            rfifo_wen_q   <= 1'b0;
            rd_err_q      <= 1'b0;
            rd_data_q     <= 32'h0000_0000;
            psel_q        <= '0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 32'h0000_0000;
            pwdata_q      <= 32'h0000_0000;
            timeout_err_q <= 1'b0;
            cnt_q         <= '0;
            cmd_addr_q    <= 30'h0;
            cmd_wdata_q   <= 32'h0000_0000;
            cmd_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            apb_state_q   <= apb_state_d;
            wfifo_ren_q   <= wfifo_ren_d;
            rfifo_wen_q   <= rfifo_wen_d;
            rd_err_q      <= rd_err_d;
            rd_data_q     <= rd_data_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            timeout_err_q <= timeout_err_d;
            cnt_q         <= cnt_d;
            cmd_addr_q    <= src_addr_s[31:2];
            cmd_wdata_q   <= src_wdata_s;
            cmd_write_q   <= src_write_s;
        end
    end

    assign bus.wfifo_ren   = wfifo_ren_q;
    assign bus.rfifo_wen   = rfifo_wen_q;
    assign bus.rfifo_wdata = {31'h0000_0000, rd_err_q, rd_data_q};
    assign bus.apb_state   = apb_state_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.paddr       = paddr_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: a small write-FIFO model feeds commands and the APB
// slave response is driven step by step; outputs are sampled on the falling clock edge.
module tb_apb_master_ctrl;
    localparam int TIMEOUT_CYC = 8;
    localparam int NUM_SLV     = 4;
    localparam int SEL_LSB     = 12;

    logic clk = 1'b0;
    logic rst;
    int   nvec = 0;
    int   nerr = 0;

    logic [63:0] wmem [0:15];
    int          wwr = 0;
    int          wrd = 0;
    int          wen_cnt = 0;
    int          ren_cnt = 0;

    apb_master_ctrl_if #(.NUM_SLV(NUM_SLV)) bus ();

    apb_master_ctrl #(
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .NUM_SLV     (NUM_SLV),
        .SEL_LSB     (SEL_LSB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.wfifo_empty = (wwr == wrd);

    // Write FIFO model (data valid the cycle after a pop) plus pulse counters.
    always @(posedge clk) begin
        if (bus.wfifo_ren && (wwr != wrd)) begin
            bus.wfifo_rdata <= wmem[wrd % 16];
            wrd             <= wrd + 1;
        end
        if (bus.rfifo_wen) wen_cnt <= wen_cnt + 1;
        if (bus.wfifo_ren) ren_cnt <= ren_cnt + 1;
    end

    task automatic push(input logic [63:0] w);
        wmem[wwr % 16] = w;
        wwr = wwr + 1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int          wen_base;
        int          ren_base;
        logic [63:0] exp_v;

        rst             = 1'b1;
        bus.apb_en      = 1'b0;
        bus.rfifo_full  = 1'b0;
        bus.prdata      = 32'h0;
        bus.pready      = 1'b0;
        bus.pslverr     = 1'b0;

        // Reset state and release sequence
        repeat (3) tick();
        chk("rst_state",   64'(bus.apb_state),   64'h0);
        chk("rst_psel",    64'(bus.psel),        64'h0);
        chk("rst_penable", 64'(bus.penable),     64'h0);
        chk("rst_ren",     64'(bus.wfifo_ren),   64'h0);
        chk("rst_wen",     64'(bus.rfifo_wen),   64'h0);
        chk("rst_paddr",   64'(bus.paddr),       64'h0);
        chk("rst_tout",    64'(bus.timeout_err), 64'h0);
        rst = 1'b0;
        tick();
        chk("rst_hold_1clk", 64'(bus.apb_state), 64'h0);
        tick();
        chk("rst_to_idle",   64'(bus.apb_state), 64'h1);

        // Single zero-wait write to slave 1
        bus.pready = 1'b1;
        bus.apb_en = 1'b1;
        push(64'hDEAD_BEEF_0000_1005);
        tick();
        chk("wr_ren",       64'(bus.wfifo_ren), 64'h1);
        chk("wr_pop_state", 64'(bus.apb_state), 64'h1);
        tick();
        chk("wr_fetch_ren",   64'(bus.wfifo_ren), 64'h0);
        chk("wr_fetch_state", 64'(bus.apb_state), 64'h1);
        tick();
        chk("wr_setup_psel",    64'(bus.psel),      64'h2);
        chk("wr_setup_penable", 64'(bus.penable),   64'h0);
        chk("wr_setup_paddr",   64'(bus.paddr),     64'h1004);
        chk("wr_setup_pwrite",  64'(bus.pwrite),    64'h1);
        chk("wr_setup_pwdata",  64'(bus.pwdata),    64'hDEAD_BEEF);
        chk("wr_setup_state",   64'(bus.apb_state), 64'h3);
        tick();
        chk("wr_access_penable", 64'(bus.penable),   64'h1);
        chk("wr_access_psel",    64'(bus.psel),      64'h2);
        chk("wr_access_state",   64'(bus.apb_state), 64'h3);
        tick();
        chk("wr_done_psel",    64'(bus.psel),      64'h0);
        chk("wr_done_penable", 64'(bus.penable),   64'h0);
        chk("wr_done_state",   64'(bus.apb_state), 64'h1);
        chk("wr_paddr_hold",   64'(bus.paddr),     64'h1004);
        tick();
        chk("wr_no_push", 64'(wen_cnt), 64'h0);

        // Read from slave 2 with three wait states
        bus.pready = 1'b0;
        bus.prdata = 32'h1234_5678;
        push(64'h0000_0000_0000_2000);
        repeat (3) tick();
        chk("rd_setup_psel",   64'(bus.psel),      64'h4);
        chk("rd_setup_pwrite", 64'(bus.pwrite),    64'h0);
        chk("rd_setup_paddr",  64'(bus.paddr),     64'h2000);
        chk("rd_setup_state",  64'(bus.apb_state), 64'h2);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rd_wait_penable", 64'(bus.penable), 64'h1);
        end
        bus.pready = 1'b1;
        tick();
        chk("rd_wen",     64'(bus.rfifo_wen),   64'h1);
        chk("rd_wdata",   bus.rfifo_wdata,      64'h0000_0000_1234_5678);
        chk("rd_penable", 64'(bus.penable),     64'h0);
        chk("rd_psel",    64'(bus.psel),        64'h0);
        tick();
        chk("rd_wen_pulse", 64'(bus.rfifo_wen), 64'h0);

        // Read to slave 3 held off by a full read FIFO
        bus.rfifo_full = 1'b1;
        bus.prdata     = 32'hCAFE_0001;
        push(64'h0000_0000_0000_3000);
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_state", 64'(bus.apb_state), 64'h2);
            chk("hold_psel",  64'(bus.psel),      64'h0);
        end
        bus.rfifo_full = 1'b0;
        tick();
        chk("hold_setup_psel",    64'(bus.psel),    64'h8);
        chk("hold_setup_penable", 64'(bus.penable), 64'h0);
        tick();
        chk("hold_access_penable", 64'(bus.penable), 64'h1);
        tick();
        chk("hold_wen",   64'(bus.rfifo_wen), 64'h1);
        chk("hold_wdata", bus.rfifo_wdata,    64'h0000_0000_CAFE_0001);

        // Unmapped slave index 5: no select, error push one cycle after SETUP
        push(64'h0000_0000_0000_5000);
        repeat (3) tick();
        chk("nosel_psel",  64'(bus.psel),      64'h0);
        chk("nosel_state", 64'(bus.apb_state), 64'h2);
        tick();
        chk("nosel_wen",     64'(bus.rfifo_wen), 64'h1);
        chk("nosel_wdata",   bus.rfifo_wdata,    64'h0000_0001_0000_0000);
        chk("nosel_penable", 64'(bus.penable),   64'h0);

        // Timeout on a read to slave 0 that never becomes ready
        bus.pready = 1'b0;
        chk("tout_clear", 64'(bus.timeout_err), 64'h0);
        push(64'h0000_0000_0000_0000);
        repeat (3) tick();
        chk("tout_setup_psel", 64'(bus.psel), 64'h1);
        for (int i = 0; i < TIMEOUT_CYC; i++) begin
            tick();
            chk("tout_penable", 64'(bus.penable), 64'h1);
        end
        tick();
        chk("tout_err",     64'(bus.timeout_err), 64'h1);
        chk("tout_psel",    64'(bus.psel),        64'h0);
        chk("tout_penable", 64'(bus.penable),     64'h0);
        chk("tout_wen",     64'(bus.rfifo_wen),   64'h1);
        chk("tout_wdata",   bus.rfifo_wdata,      64'h0000_0001_0000_0000);
        tick();
        chk("tout_sticky",  64'(bus.timeout_err), 64'h1);

        // Gated queue, then three back-to-back writes (slave errors must not push)
        bus.apb_en  = 1'b0;
        bus.pready  = 1'b1;
        bus.pslverr = 1'b1;
        push(64'hA000_0001_0000_1001);
        push(64'hA000_0002_0000_2001);
        push(64'hA000_0003_0000_3001);
        wen_base = wen_cnt;
        ren_base = ren_cnt;
        repeat (3) tick();
        chk("gate_no_pop", 64'(ren_cnt),       64'(ren_base));
        chk("gate_idle",   64'(bus.apb_state), 64'h1);
        bus.apb_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            exp_v = ((i % 4 == 0) && (i < 12)) ? 64'h1 : 64'h0;
            chk("b2b_ren", 64'(bus.wfifo_ren), exp_v);
            exp_v = ((i % 4 >= 2) && (i < 12)) ? (64'h1 << (i / 4 + 1)) : 64'h0;
            chk("b2b_psel", 64'(bus.psel), exp_v);
        end
        chk("b2b_pwdata",  64'(bus.pwdata), 64'hA000_0003);
        chk("b2b_no_push", 64'(wen_cnt),    64'(wen_base));

        // apb_en dropped during the second transfer: it finishes, the third never starts
        bus.apb_en  = 1'b0;
        bus.pslverr = 1'b0;
        push(64'hB000_0001_0000_1011);
        push(64'hB000_0002_0000_2011);
        push(64'hB000_0003_0000_3011);
        tick();
        chk("gate2_idle_ren", 64'(bus.wfifo_ren), 64'h0);
        bus.apb_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            exp_v = ((i == 0) || (i == 4)) ? 64'h1 : 64'h0;
            chk("gate2_ren", 64'(bus.wfifo_ren), exp_v);
            if (i == 5) bus.apb_en = 1'b0;
        end
        chk("gate2_paddr", 64'(bus.paddr),     64'h2010);
        chk("gate2_left",  64'(wwr - wrd),     64'h1);
        chk("gate2_state", 64'(bus.apb_state), 64'h1);

        // Reset asserted in the middle of ACCESS
        bus.pready = 1'b0;
        bus.apb_en = 1'b1;
        repeat (4) tick();
        chk("mid_access_penable", 64'(bus.penable), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_psel",    64'(bus.psel),        64'h0);
        chk("mid_rst_penable", 64'(bus.penable),     64'h0);
        chk("mid_rst_state",   64'(bus.apb_state),   64'h0);
        chk("mid_rst_tout",    64'(bus.timeout_err), 64'h0);
        chk("mid_rst_paddr",   64'(bus.paddr),       64'h0);
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rel_hold",  64'(bus.apb_state), 64'h0);
        tick();
        chk("mid_rel_idle",  64'(bus.apb_state), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Sits directly downstream of the ICB slave register bank and its write FIFO.
- Pops 64-bit command words from the WFIFO and runs each one as a single APB3 transfer.
- Pushes read results into the RFIFO.
- Reports its FSM phase on the 2-bit apb_state field that the ICB side exposes in the STATE register.

Parameters:
TIMEOUT_CYC, 256, ACCESS cycles with PREADY low before the transfer is aborted (≥2)
NUM_SLV, 4, number of PSEL lines (1..8)
SEL_LSB, 12, lowest PADDR bit of the slave-select field; field is PADDR[SEL_LSB+2:SEL_LSB]

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
apb_en  in  1  control[0] from register bank; 1 = transfers allowed
wfifo_empty  in  1  write FIFO empty
wfifo_rdata  in  64  write FIFO data; valid the cycle after wfifo_ren
wfifo_ren  out  1  write FIFO pop, one-cycle pulse
rfifo_full  in  1  read FIFO full
rfifo_wen  out  1  read FIFO push, one-cycle pulse
rfifo_wdata  out  64  {31'b0, err, 32-bit read data}
apb_state  out  2  0 = reset, 1 = free, 2 = read, 3 = write
psel  out  NUM_SLV  one-hot APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  32  APB address
pwdata  out  32  APB write data
prdata  in  32  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error
timeout_err  out  1  sticky; set on timeout, cleared only by rst

Behaviour:
- Command word format:
  - [63:32] = PWDATA
  - [31:2] = PADDR[31:2]; PADDR[1:0] is forced to 0
  - [1] reserved
  - [0] = PWRITE
- Slave index = PADDR[SEL_LSB+2:SEL_LSB]. An index ≥ NUM_SLV drives no PSEL; the transfer completes the next cycle with err=1.
- All outputs are registered.
- Asserting rst clears every output to 0 immediately, including in the middle of a transfer; the FSM goes to RST.
- FSM states and transitions:
  - RST (apb_state=0): after rst deasserts, stays exactly one clk, then → IDLE.
  - IDLE (apb_state=1): if apb_en && !wfifo_empty, pulse wfifo_ren and go → FETCH; otherwise stay.
  - FETCH (apb_state=1): latch wfifo_rdata into the command register.
    - Write command → SETUP.
    - Read command with !rfifo_full → SETUP.
    - Read command with rfifo_full → HOLD.
  - HOLD (apb_state=2): wait until !rfifo_full, then → SETUP. PSEL stays low while holding.
  - SETUP (apb_state=2 for read, 3 for write): PSEL set, PENABLE=0, paddr/pwrite/pwdata driven. → ACCESS.
  - ACCESS (same apb_state as SETUP): PENABLE=1; a counter increments every cycle pready=0.
    - pready=1: drop PSEL and PENABLE next cycle. For a read, pulse rfifo_wen next cycle with rfifo_wdata = {31'b0, pslverr, prdata}. → IDLE.
    - Counter reaches TIMEOUT_CYC: abort. Drop PSEL and PENABLE, set timeout_err. For a read, push {31'b0, 1'b1, 32'h0}. → IDLE.
- paddr, pwrite and pwdata hold their values from SETUP until the next SETUP.
- A write that gets pslverr produces no rfifo push; the error is dropped.
- Deasserting apb_en affects only IDLE. A transfer already in FETCH..ACCESS finishes normally.
- The timeout counter resets on entry to SETUP.
- Throughput: minimum 4 clk per transfer with zero-wait slaves (ren → FETCH → SETUP → ACCESS). The next wfifo_ren can fire in the same cycle as the previous rfifo_wen.
- At most one command is in flight; no pipelining.

Test Plan:
- Reset: rst=1 mid-ACCESS → psel=0, penable=0, apb_state=0 same cycle. Release rst → apb_state=1 two clk later.
- Single write, apb_en=1, word {32'hDEADBEEF, 32'h0000_1005}, pready=1 → SETUP: psel=4'b0010, paddr=32'h1004, pwrite=1, pwdata=32'hDEADBEEF. ACCESS 1 clk, apb_state=3 for 2 clk, no rfifo_wen.
- Read with 3 wait states, prdata=32'h12345678, pslverr=0 → penable high 4 clk. rfifo_wen one pulse, rfifo_wdata=64'h0000_0000_1234_5678.
- Read with rfifo_full=1 for 5 clk → FSM in HOLD with apb_state=2 and psel=0. SETUP starts the cycle after rfifo_full falls.
- Timeout, TIMEOUT_CYC=8, pready held 0 on a read → abort after 8 ACCESS clk. timeout_err=1, rfifo_wdata=64'h0000_0001_0000_0000.
- Gating: 3 commands queued with apb_en=0 → no wfifo_ren. Raise apb_en → 3 transfers back-to-back, 4 clk each. Drop apb_en during the 2nd transfer → it completes and the 3rd does not start.
